// File: rtl/dmem_unit.sv
// Data memory unit: one request in flight, fixed LAT-cycle response,
// byte/half/word loads and stores with alignment and range fault checks.
module dmem_unit #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] mem_q [DEPTH];

  logic              fault;
  logic              mem_we;
  logic [ADDR_W-1:0] widx;
  logic [4:0]        lane_lsb;
  logic [31:0]       rd_word;
  logic [31:0]       wr_word;
  logic [31:0]       ld_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign widx     = addr_q[ADDR_W+1:2];
  assign lane_lsb = {addr_q[1:0], 3'b000};
  assign rd_word  = mem_q[widx];
  assign ld_byte  = rd_word[lane_lsb +: 8];
  assign ld_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    fault = 1'b0;
    case (op_q)
      3'd0:       fault = (addr_q[1:0] != 2'b00);
      3'd1, 3'd2: fault = addr_q[0];
      3'd3, 3'd4: fault = 1'b0;
      default:    fault = 1'b1;
    endcase
    // Unsigned variants only make sense for loads.
    if (we_q && (op_q == 3'd2 || op_q == 3'd4)) fault = 1'b1;
    if ((addr_q >> (ADDR_W + 2)) != 32'd0) fault = 1'b1;
  end

  always_comb begin
    ld_data = 32'd0;
    case (op_q)
      3'd0:    ld_data = rd_word;
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_data = {16'd0, ld_half};
      3'd3:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_data = {24'd0, ld_byte};
      default: ld_data = 32'd0;
    endcase
  end

  always_comb begin
    wr_word = rd_word;
    case (op_q)
      3'd0: wr_word = wdata_q;
      3'd1: begin
        if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
        else           wr_word[15:0]  = wdata_q[15:0];
      end
      3'd3:    wr_word[lane_lsb +: 8] = wdata_q[7:0];
      default: wr_word = rd_word;
    endcase
  end

  assign mem_we     = (state_q == RESP) && we_q && !fault;
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && fault;
  assign resp_rdata = (resp_valid && !we_q && !fault) ? ld_data : 32'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          pc_d    = req_pc;
          cnt_d   = 3'(LAT - 1);
          state_d = (LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      op_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (mem_we) begin
      mem_q[widx] <= wr_word;
    end
  end

`ifndef SYNTHESIS
  // Store trace; the reset guard keeps aborted stores out of the log.
  always_ff @(posedge clk) begin
    if (!reset && mem_we)
      $display("@%08h: *%08h <= %08h", pc_q, addr_q, wdata_q);
  end
`endif

endmodule

// File: tb/tb_dmem_unit.sv
// Bench for dmem_unit: three instances (LAT 2, 1, 7) checked against a
// byte-addressed reference memory with directed and random traffic.
module tb_dmem_unit;

  logic        clk;
  logic        reset;
  logic        rv   [3];
  logic        rdy  [3];
  logic        rwe  [3];
  logic [2:0]  rop  [3];
  logic [31:0] radr [3];
  logic [31:0] rwd  [3];
  logic [31:0] rpc  [3];
  logic        rsv  [3];
  logic [31:0] rrd  [3];
  logic        rerr [3];

  int          lats [3];
  logic [7:0]  mb   [3][4096];
  int          vectors;
  int          miscompares;
  logic [31:0] rd;

  dmem_unit #(.ADDR_W(10), .LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_we(rwe[0]), .req_op(rop[0]), .req_addr(radr[0]), .req_wdata(rwd[0]),
    .req_pc(rpc[0]), .resp_valid(rsv[0]), .resp_rdata(rrd[0]), .resp_err(rerr[0])
  );

  dmem_unit #(.ADDR_W(10), .LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_we(rwe[1]), .req_op(rop[1]), .req_addr(radr[1]), .req_wdata(rwd[1]),
    .req_pc(rpc[1]), .resp_valid(rsv[1]), .resp_rdata(rrd[1]), .resp_err(rerr[1])
  );

  dmem_unit #(.ADDR_W(10), .LAT(7)) u_lat7 (
    .clk(clk), .reset(reset), .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_we(rwe[2]), .req_op(rop[2]), .req_addr(radr[2]), .req_wdata(rwd[2]),
    .req_pc(rpc[2]), .resp_valid(rsv[2]), .resp_rdata(rrd[2]), .resp_err(rerr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: 4 KiB byte array per instance, little-endian.
  function automatic bit m_fault(input bit w, input logic [2:0] o, input logic [31:0] a);
    int size;
    if (o > 3'd4) return 1'b1;
    if (w && (o == 3'd2 || o == 3'd4)) return 1'b1;
    if (a >= 32'd4096) return 1'b1;
    size = (o == 3'd0) ? 4 : (o <= 3'd2) ? 2 : 1;
    if ((a % size) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input int s, input logic [2:0] o, input logic [31:0] a);
    int ai;
    int v;
    ai = int'(a[11:0]);
    case (o)
      3'd0: v = int'({mb[s][ai+3], mb[s][ai+2], mb[s][ai+1], mb[s][ai]});
      3'd1, 3'd2: begin
        v = mb[s][ai] + 256 * mb[s][ai+1];
        if (o == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: begin
        v = mb[s][ai];
        if (o == 3'd3 && v >= 128) v = v - 256;
      end
    endcase
    return v;
  endfunction

  task automatic m_store(input int s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    int ai;
    int size;
    logic [31:0] dd;
    ai = int'(a[11:0]);
    size = (o == 3'd0) ? 4 : (o == 3'd1) ? 2 : 1;
    dd = d;
    for (int i = 0; i < size; i++) begin
      mb[s][ai+i] = dd[7:0];
      dd = dd >> 8;
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 4096; i++) mb[s][i] = 8'd0;
  endtask

  // Called at a negedge; returns at the negedge where the response is seen.
  task automatic do_txn(input int s, input bit w, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] r, output logic e, output int lat);
    int g;
    r = 'x;
    e = 1'bx;
    lat = -1;
    g = 0;
    while (!rdy[s] && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("ready_wait", {31'd0, rdy[s]}, 32'd1);
    rv[s]   = 1'b1;
    rwe[s]  = w;
    rop[s]  = o;
    radr[s] = a;
    rwd[s]  = d;
    rpc[s]  = $urandom;
    @(posedge clk);
    @(negedge clk);
    rv[s] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (rsv[s]) begin
        lat = k;
        r = rrd[s];
        e = rerr[s];
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic txn(input int s, input bit w, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] r);
    bit          ef;
    logic [31:0] erd;
    logic        e;
    int          lat;
    ef  = m_fault(w, o, a);
    erd = (ef || w) ? 32'd0 : m_load(s, o, a);
    do_txn(s, w, o, a, d, r, e, lat);
    check("latency", lat, lats[s]);
    check("err", {31'd0, e}, {31'd0, ef});
    check("rdata", r, erd);
    if (!ef && w) m_store(s, o, a, d);
  endtask

  // Keeps req_valid high throughout; a new request is presented whenever ready.
  task automatic sweep(input int s, input int n);
    int          cyc;
    int          acc_cyc;
    int          outst;
    int          nresp;
    int          budget;
    bit          ef;
    bit          ew;
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] erd;
    cyc = 0;
    acc_cyc = 0;
    outst = 0;
    nresp = 0;
    ef = 1'b0;
    erd = 32'd0;
    budget = n * (lats[s] + 2) + 20;
    rv[s] = 1'b1;
    while (nresp < n && cyc < budget) begin
      if (rsv[s]) begin
        check("sw_outstanding", outst, 1);
        check("sw_latency", cyc - acc_cyc, lats[s]);
        check("sw_err", {31'd0, rerr[s]}, {31'd0, ef});
        check("sw_rdata", rrd[s], erd);
        outst = 0;
        nresp++;
      end else begin
        check("sw_idle_rdata", rrd[s], 32'd0);
      end
      if (rdy[s] && nresp < n) begin
        check("sw_no_overlap", outst, 0);
        ew = 1'($urandom_range(0, 1));
        o  = 3'($urandom_range(0, 5));
        a  = $urandom_range(0, 63);
        if ($urandom_range(0, 7) == 0) a = a | 32'h0000_1000;
        d  = $urandom;
        rwe[s] = ew;
        rop[s] = o;
        radr[s] = a;
        rwd[s] = d;
        rpc[s] = $urandom;
        ef  = m_fault(ew, o, a);
        erd = (ef || ew) ? 32'd0 : m_load(s, o, a);
        if (!ef && ew) m_store(s, o, a, d);
        acc_cyc = cyc;
        outst = 1;
      end
      @(negedge clk);
      cyc++;
    end
    rv[s] = 1'b0;
    check("sw_response_count", nresp, n);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    lats[0] = 2;
    lats[1] = 1;
    lats[2] = 7;
    for (int s = 0; s < 3; s++) begin
      rv[s] = 1'b0;
      rwe[s] = 1'b0;
      rop[s] = 3'd0;
      radr[s] = 32'd0;
      rwd[s] = 32'd0;
      rpc[s] = 32'd0;
    end
    m_clear();

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'd0, rsv[0]}, 32'd0);
    check("rst_resp_err", {31'd0, rerr[0]}, 32'd0);
    check("rst_resp_rdata", rrd[0], 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, rdy[0]}, 32'd1);

    // Word store/load, then byte and half lanes.
    txn(0, 1'b1, 3'd0, 32'h10, 32'h1234_5678, rd);
    txn(0, 1'b0, 3'd0, 32'h10, 32'h0, rd);
    check("ld_w_10", rd, 32'h1234_5678);
    txn(0, 1'b1, 3'd3, 32'h11, 32'h0000_00AB, rd);
    txn(0, 1'b0, 3'd3, 32'h11, 32'h0, rd);
    check("ld_b_11", rd, 32'hFFFF_FFAB);
    txn(0, 1'b0, 3'd4, 32'h11, 32'h0, rd);
    check("ld_bu_11", rd, 32'h0000_00AB);
    txn(0, 1'b0, 3'd0, 32'h10, 32'h0, rd);
    check("ld_w_merge", rd, 32'h1234_AB78);
    txn(0, 1'b1, 3'd1, 32'h12, 32'h0000_8001, rd);
    txn(0, 1'b0, 3'd1, 32'h12, 32'h0, rd);
    check("ld_h_12", rd, 32'hFFFF_8001);
    txn(0, 1'b0, 3'd2, 32'h12, 32'h0, rd);
    check("ld_hu_12", rd, 32'h0000_8001);

    // Faulting accesses leave memory untouched.
    txn(0, 1'b0, 3'd0, 32'h13, 32'h0, rd);
    txn(0, 1'b1, 3'd1, 32'h11, 32'h0000_5555, rd);
    txn(0, 1'b0, 3'd6, 32'h10, 32'h0, rd);
    txn(0, 1'b0, 3'd0, 32'h0000_1000, 32'h0, rd);
    txn(0, 1'b1, 3'd0, 32'h0000_1010, 32'hFFFF_FFFF, rd);
    txn(0, 1'b1, 3'd4, 32'h10, 32'h0000_00FF, rd);
    txn(0, 1'b0, 3'd0, 32'h10, 32'h0, rd);
    check("ld_w_after_faults", rd, 32'h8001_AB78);

    // Reset while a store is waiting.
    @(negedge clk);
    rv[0] = 1'b1;
    rwe[0] = 1'b1;
    rop[0] = 3'd0;
    radr[0] = 32'h20;
    rwd[0] = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    rv[0] = 1'b0;
    check("abort_wait_no_resp", {31'd0, rsv[0]}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_rst_no_resp", {31'd0, rsv[0]}, 32'd0);
    reset = 1'b0;
    m_clear();
    @(posedge clk);
    @(negedge clk);
    check("abort_ready_after_rst", {31'd0, rdy[0]}, 32'd1);
    txn(0, 1'b0, 3'd0, 32'h20, 32'h0, rd);
    check("abort_word_20", rd, 32'd0);

    // Random single transactions on the LAT=2 instance.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      ra = $urandom_range(0, 127);
      if ($urandom_range(0, 9) == 0) ra = ra | (32'h1 << $urandom_range(12, 31));
      txn(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, rd);
    end

    // Back-to-back sweeps at the latency extremes.
    @(negedge clk);
    sweep(1, 30);
    sweep(2, 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
